// File: rtl/cred_enroll_writer_pkg.sv
// Shared constants, FSM state encoding and error codes for the credential
// enrolment writer. The PASS_CONF state exists only when
// CRED_ENROLL_CONFIRM_EN is defined.
package cred_pkg;

  localparam int NIB_W     = 4;
  localparam int USER_W    = 16;
  localparam int PASS_W    = 20;
  localparam int ADDR_W    = 3;
  localparam int DEPTH     = 8;

  localparam int USER_NIBS = USER_W / NIB_W;
  localparam int PASS_NIBS = PASS_W / NIB_W;

  // Slot count at which the store is full, sized like the count output.
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_USER_ENT,
    ST_SCAN,
    ST_PASS_ENT,
`ifdef CRED_ENROLL_CONFIRM_EN
    ST_PASS_CONF,
`endif
    ST_WRITE,
    ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_FULL = 2'd1,
    ERR_DUP  = 2'd2,
    ERR_BAD  = 2'd3
  } err_e;

endpackage

// File: rtl/cred_enroll_writer_nibble_shift_reg.sv
// N-nibble shift register fed MSB first. Counts presses, ignores presses
// once full, and flags the press that will complete the field.
module nibble_shift_reg
  import cred_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic [NIB_W-1:0]   nib,
  output logic [N*NIB_W-1:0] data,
  output logic               last
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N);

  logic [CNT_W-1:0] cnt_q;
  logic             full;

  assign full = (cnt_q == FULL_CNT);
  assign last = (cnt_q == LAST_CNT);

  // Shift one nibble in at the bottom per press; clear restarts the field.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst || clr) begin
      data  <= '0;
      cnt_q <= '0;
    end else if (shift && !full) begin
      data  <= {data[N*NIB_W-NIB_W-1:0], nib};
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cred_enroll_writer.sv
// Credential enrolment writer: collects a user ID and password from nibble
// presses, scans the user RAM for duplicates, then writes one slot.
// Optional feature: define CRED_ENROLL_CONFIRM_EN for password re-entry.
module cred_enroll_writer
  import cred_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enroll_start,
  input  logic              b_in,
  input  logic [NIB_W-1:0]  swt_in,
  input  logic [USER_W-1:0] rd_user,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [USER_W-1:0] wr_user,
  output logic [PASS_W-1:0] wr_pass,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   count,
  output logic [2:0]        nib_idx
);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  err_e                err_q, err_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [2:0]          nib_q, nib_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                issue_q, issue_d;         // still stepping rd_addr
  logic                pend_q, pend_d;           // rd_user this cycle is a scan result
  logic                pend_last_q, pend_last_d; // that result is slot count-1

  logic                user_clr, user_shift, user_last;
  logic                pass_clr, pass_shift, pass_last;
  logic [USER_W-1:0]   user_q, user_cand;
  logic [PASS_W-1:0]   pass_q;
  logic                scan_hit, scan_end_addr;

  nibble_shift_reg #(.N(USER_NIBS)) u_user_sr (
    .clk(clk), .rst(rst), .clr(user_clr), .shift(user_shift),
    .nib(swt_in), .data(user_q), .last(user_last)
  );

  nibble_shift_reg #(.N(PASS_NIBS)) u_pass_sr (
    .clk(clk), .rst(rst), .clr(pass_clr), .shift(pass_shift),
    .nib(swt_in), .data(pass_q), .last(pass_last)
  );

  // User value as it will be once the current press is shifted in.
  assign user_cand     = {user_q[USER_W-NIB_W-1:0], swt_in};
  assign scan_hit      = pend_q && (rd_user == user_q);
  assign scan_end_addr = ({1'b0, rd_addr_q} == count_q - 1'b1);

`ifdef CRED_ENROLL_CONFIRM_EN
  logic              conf_clr, conf_shift, conf_last, conf_ok;
  logic [PASS_W-1:0] conf_q;

  nibble_shift_reg #(.N(PASS_NIBS)) u_conf_sr (
    .clk(clk), .rst(rst), .clr(conf_clr), .shift(conf_shift),
    .nib(swt_in), .data(conf_q), .last(conf_last)
  );

  assign conf_ok = ({conf_q[PASS_W-NIB_W-1:0], swt_in} == pass_q);
`endif

  // State and registered outputs; synchronous reset aborts any enrolment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      wr_en_q     <= 1'b0;
      count_q     <= '0;
      nib_q       <= '0;
      rd_addr_q   <= '0;
      issue_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      count_q     <= count_d;
      nib_q       <= nib_d;
      rd_addr_q   <= rd_addr_d;
      issue_q     <= issue_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  // Next-state decision.
  always_comb begin
    // NOTE: default first so no path through the case leaves a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (enroll_start && count_q != DEPTH_CNT) state_d = ST_USER_ENT;
      ST_USER_ENT:
        if (b_in && user_last) begin
          if (user_cand == '0)    state_d = ST_IDLE;
          else if (count_q == '0) state_d = ST_PASS_ENT;
          else                    state_d = ST_SCAN;
        end
      ST_SCAN:
        if (scan_hit)                   state_d = ST_IDLE;
        else if (pend_q && pend_last_q) state_d = ST_PASS_ENT;
      ST_PASS_ENT:
        if (b_in && pass_last) begin
`ifdef CRED_ENROLL_CONFIRM_EN
          state_d = ST_PASS_CONF;
`else
          state_d = ST_WRITE;
`endif
        end
`ifdef CRED_ENROLL_CONFIRM_EN
      ST_PASS_CONF:
        if (b_in && conf_last) state_d = conf_ok ? ST_WRITE : ST_IDLE;
`endif
      ST_WRITE: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath controls: values the output registers take next.
  always_comb begin
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    count_d     = count_q;
    nib_d       = nib_q;
    rd_addr_d   = rd_addr_q;
    issue_d     = issue_q;
    pend_d      = 1'b0;
    pend_last_d = 1'b0;
    user_clr    = 1'b0;
    user_shift  = 1'b0;
    pass_clr    = 1'b0;
    pass_shift  = 1'b0;
`ifdef CRED_ENROLL_CONFIRM_EN
    conf_clr    = 1'b0;
    conf_shift  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE:
        if (enroll_start) begin
          if (count_q == DEPTH_CNT) begin
            done_d = 1'b1;
            err_d  = ERR_FULL;
          end else begin
            err_d    = ERR_OK;
            busy_d   = 1'b1;
            nib_d    = '0;
            user_clr = 1'b1;
            pass_clr = 1'b1;
`ifdef CRED_ENROLL_CONFIRM_EN
            conf_clr = 1'b1;
`endif
          end
        end
      ST_USER_ENT:
        if (b_in) begin
          user_shift = 1'b1;
          nib_d      = nib_q + 3'd1;
          if (user_last) begin
            if (user_cand == '0) begin
              done_d = 1'b1;
              err_d  = ERR_BAD;
              busy_d = 1'b0;
            end else if (count_q == '0) begin
              nib_d = '0;
            end else begin
              rd_addr_d = '0;
              issue_d   = 1'b1;
            end
          end
        end
      ST_SCAN: begin
        pend_d      = issue_q;
        pend_last_d = issue_q && scan_end_addr;
        if (issue_q) begin
          if (scan_end_addr) issue_d = 1'b0;
          else               rd_addr_d = rd_addr_q + 1'b1;
        end
        if (scan_hit) begin
          done_d      = 1'b1;
          err_d       = ERR_DUP;
          busy_d      = 1'b0;
          issue_d     = 1'b0;
          pend_d      = 1'b0;
          pend_last_d = 1'b0;
        end else if (pend_q && pend_last_q) begin
          nib_d = '0;
        end
      end
      ST_PASS_ENT:
        if (b_in) begin
          pass_shift = 1'b1;
          nib_d      = nib_q + 3'd1;
          if (pass_last) begin
`ifdef CRED_ENROLL_CONFIRM_EN
            nib_d   = '0;
`else
            wr_en_d = 1'b1;
`endif
          end
        end
`ifdef CRED_ENROLL_CONFIRM_EN
      ST_PASS_CONF:
        if (b_in) begin
          conf_shift = 1'b1;
          nib_d      = nib_q + 3'd1;
          if (conf_last) begin
            if (conf_ok) begin
              wr_en_d = 1'b1;
            end else begin
              done_d = 1'b1;
              err_d  = ERR_BAD;
              busy_d = 1'b0;
            end
          end
        end
`endif
      ST_WRITE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (count_q != DEPTH_CNT) count_d = count_q + 1'b1;
      end
      ST_FIN: ;
      default: ;
    endcase
  end

  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = count_q[ADDR_W-1:0];
  assign wr_user = user_q;
  assign wr_pass = pass_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign count   = count_q;
  assign nib_idx = nib_q;

endmodule

// File: tb/tb_cred_enroll_writer.sv
// Self-checking bench for cred_enroll_writer: a table of enrolments, hand
// sequences for timing corners, then random enrolments against a queue model.
module tb_cred_enroll_writer;

`ifdef CRED_ENROLL_CONFIRM_EN
  localparam bit CONFIRM = 1'b1;
`else
  localparam bit CONFIRM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enroll_start = 1'b0;
  logic        b_in = 1'b0;
  logic [3:0]  swt_in = '0;
  logic [15:0] rd_user = '0;
  logic [2:0]  rd_addr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_user;
  logic [19:0] wr_pass;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [3:0]  count;
  logic [2:0]  nib_idx;

  cred_enroll_writer dut (
    .clk(clk), .rst(rst), .enroll_start(enroll_start), .b_in(b_in),
    .swt_in(swt_in), .rd_user(rd_user), .rd_addr(rd_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_user(wr_user), .wr_pass(wr_pass), .busy(busy),
    .done(done), .err(err), .count(count), .nib_idx(nib_idx)
  );

  always #5 clk = ~clk;

  // User RAM: synchronous read, written by the DUT's write port.
  logic [15:0] umem [8];
  initial for (int i = 0; i < 8; i++) umem[i] = '0;
  always @(posedge clk) begin
    if (wr_en) umem[wr_addr] <= wr_user;
    rd_user <= umem[rd_addr];
  end

  // Monitor: done pulses and write cycles observed mid-cycle.
  typedef struct { logic [2:0] a; logic [15:0] u; logic [19:0] p; } wr_t;
  wr_t        wr_q[$];
  int         done_cnt = 0;
  logic [1:0] done_err = '0;
  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_err = err;
    end
    if (wr_en) wr_q.push_back('{wr_addr, wr_user, wr_pass});
  end

  // Reference model: list of enrolled users.
  logic [15:0] m_users[$];

  function automatic logic [1:0] model_err(input logic [15:0] u,
                                           input logic [19:0] p, p2);
    if (m_users.size() == 8) return 2'd1;
    if (u == 16'h0000) return 2'd3;
    foreach (m_users[i]) if (m_users[i] == u) return 2'd2;
    if (CONFIRM && p != p2) return 2'd3;
    return 2'd0;
  endfunction

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] n);
    swt_in = n;
    b_in   = 1'b1;
    tick;
    b_in   = 1'b0;
    tick;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  // Full enrolment attempt followed by checks of outcome, write and count.
  task automatic enroll_check(input string tag, input logic [15:0] u,
                              input logic [19:0] p, input logic [19:0] p2,
                              input logic [1:0] exp_err, input logic [3:0] exp_cnt);
    int  d0;
    int  w0;
    int  nw;
    wr_t rec;
    d0 = done_cnt;
    w0 = wr_q.size();
    enroll_start = 1'b1;
    tick;
    enroll_start = 1'b0;
    for (int i = 0; i < 4; i++) press(u[15-4*i -: 4]);
    repeat (12) tick;
    if (done_cnt == d0) begin
      for (int i = 0; i < 5; i++) press(p[19-4*i -: 4]);
      if (CONFIRM) for (int i = 0; i < 5; i++) press(p2[19-4*i -: 4]);
      for (int k = 0; k < 20 && done_cnt == d0; k++) tick;
    end
    tick;
    nw = wr_q.size() - w0;
    check({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, " err"}, 64'(done_err), 64'(exp_err));
    check({tag, " writes"}, 64'(nw), (exp_err == 2'd0) ? 64'd1 : 64'd0);
    if (nw == 1) begin
      rec = wr_q[$];
      check({tag, " wr_addr"}, 64'(rec.a), 64'(exp_cnt - 4'd1));
      check({tag, " wr_user"}, 64'(rec.u), 64'(u));
      check({tag, " wr_pass"}, 64'(rec.p), 64'(p));
    end
    check({tag, " count"}, 64'(count), 64'(exp_cnt));
    check({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [15:0] u;
    logic [19:0] p;
    logic [19:0] p2;
    logic [1:0]  e;
    logic [3:0]  c;
  } vec_t;

  vec_t        tbl[8];
  logic [15:0] pool[10];

  initial begin
    int          w0;
    int          d0;
    logic [15:0] u;
    logic [19:0] p;
    logic [19:0] p2;
    logic [1:0]  e;

    tbl[0] = '{16'h1234, 20'hABCDE, 20'hABCDE, 2'd0, 4'd1};
    tbl[1] = '{16'h1234, 20'h11111, 20'h11111, 2'd2, 4'd1};
    tbl[2] = '{16'h0000, 20'h22222, 20'h22222, 2'd3, 4'd1};
    tbl[3] = '{16'h5678, 20'h12345, 20'h12345, 2'd0, 4'd2};
    tbl[4] = '{16'h1234, 20'h33333, 20'h33333, 2'd2, 4'd2};
    tbl[5] = '{16'h5678, 20'h44444, 20'h44444, 2'd2, 4'd2};
    tbl[6] = '{16'h0001, 20'h00000, 20'h00000, 2'd0, 4'd3};
    tbl[7] = '{16'h9ABC, 20'hABCDE, 20'hABCDF, CONFIRM ? 2'd3 : 2'd0,
               CONFIRM ? 4'd3 : 4'd4};

    // Reset state: every output low.
    do_reset;
    check("reset outputs",
          64'({busy, done, err, wr_en, count, nib_idx, rd_addr, wr_addr, wr_user, wr_pass}),
          64'd0);

    // Table-driven enrolments from an empty store.
    for (int i = 0; i < 8; i++) begin
      enroll_check($sformatf("tbl%0d", i), tbl[i].u, tbl[i].p, tbl[i].p2, tbl[i].e, tbl[i].c);
      if (tbl[i].e == 2'd0) m_users.push_back(tbl[i].u);
    end

    // Illegal user: done/err appear right after the 4th press, no write.
    w0 = wr_q.size();
    enroll_start = 1'b1;
    tick;
    enroll_start = 1'b0;
    press(4'h0);
    check("user nib_idx after 1", 64'(nib_idx), 64'd1);
    press(4'h0);
    press(4'h0);
    swt_in = 4'h0;
    b_in   = 1'b1;
    tick;
    b_in   = 1'b0;
    check("bad user done now", 64'({done, err, busy}), 64'({1'b1, 2'd3, 1'b0}));
    tick;
    check("bad user done pulse", 64'(done), 64'd0);
    check("bad user no write", 64'(wr_q.size() - w0), 64'd0);

    // Reset during password entry: aborted, no write, fresh enrol uses slot 0.
    do_reset;
    m_users.delete();
    w0 = wr_q.size();
    enroll_start = 1'b1;
    tick;
    enroll_start = 1'b0;
    for (int i = 0; i < 4; i++) press(4'h4 - 4'(i % 2) * 4'h2);
    repeat (3) tick;
    press(4'h7);
    press(4'h8);
    press(4'h9);
    check("pass mid busy/nib", 64'({busy, nib_idx}), 64'({1'b1, 3'd3}));
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("abort state", 64'({busy, done, count, nib_idx}), 64'd0);
    repeat (3) tick;
    check("abort no write", 64'(wr_q.size() - w0), 64'd0);
    enroll_check("fresh", 16'h4242, 20'h789AB, 20'h789AB, 2'd0, 4'd1);
    m_users.push_back(16'h4242);

    // Random enrolments against the model.
    for (int i = 0; i < 10; i++) pool[i] = 16'($urandom_range(1, 65535));
    for (int r = 0; r < 20; r++) begin
      u  = ($urandom_range(0, 9) == 0) ? 16'h0000 : pool[$urandom_range(0, 9)];
      p  = 20'($urandom);
      p2 = ($urandom_range(0, 3) == 0) ? (p ^ 20'h00010) : p;
      e  = model_err(u, p, p2);
      if (e == 2'd0) m_users.push_back(u);
      enroll_check($sformatf("rnd%0d", r), u, p, p2, e, 4'(m_users.size()));
    end

    // Fill the store, then a start must report FULL on the very next cycle.
    for (int i = 0; i < 40 && m_users.size() < 8; i++) begin
      u = 16'hC000 | 16'(i);
      e = model_err(u, 20'h13579, 20'h13579);
      if (e == 2'd0) m_users.push_back(u);
      enroll_check($sformatf("fill%0d", i), u, 20'h13579, 20'h13579, e, 4'(m_users.size()));
    end
    w0 = wr_q.size();
    d0 = done_cnt;
    enroll_start = 1'b1;
    tick;
    enroll_start = 1'b0;
    check("full done now", 64'({done, err, busy}), 64'({1'b1, 2'd1, 1'b0}));
    tick;
    check("full after", 64'({done, busy, count}), 64'({1'b0, 1'b0, 4'd8}));
    press(4'h5);
    repeat (3) tick;
    check("full single done", 64'(done_cnt - d0), 64'd1);
    check("full no write", 64'(wr_q.size() - w0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Run-time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
